product_accumulator: RTL

Sequential consumer placed directly downstream of the 8x8 Wallace multiplier. It registers each 16-bit unsigned product and sums a group of products into a wide accumulator. It presents the group total, beat count and an overflow flag through a valid/ready output handshake. It turns the combinational multiplier into a multiply-accumulate datapath for dot-product style workloads.

---
 rtl/pa_pkg.sv | 14 +
 rtl/pa_in_reg.sv | 33 +++
 rtl/product_accumulator.sv | 94 +++++++++
 3 files changed

// File: rtl/pa_pkg.sv
// Shared types and default widths for the product accumulator datapath.
package pa_pkg;

  localparam int PA_PROD_W = 16;
  localparam int PA_ACC_W  = 24;
  localparam int PA_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } pa_state_t;

endpackage

// File: rtl/pa_in_reg.sv
// Valid/last/data pipeline register with load and flush; flush wins over load.
module pa_in_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] data,
  input  logic              last,
  output logic              reg_valid,
  output logic [DATA_W-1:0] reg_data,
  output logic              reg_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_valid <= 1'b0;
      reg_data  <= '0;
      reg_last  <= 1'b0;
    end else if (flush) begin
      reg_valid <= 1'b0;
      reg_last  <= 1'b0;
    end else begin
      reg_valid <= load;
      if (load) begin
        reg_data <= data;
        reg_last <= last;
      end
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Registers multiplier products and sums each in_last-terminated group into a
// wide accumulator, handing the total, beat count and overflow flag downstream.
module product_accumulator
  import pa_pkg::*;
#(
  parameter int PROD_W = PA_PROD_W,
  parameter int ACC_W  = PA_ACC_W,
  parameter int CNT_W  = PA_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  sum_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              ovf_out,
  output logic              out_valid,
  input  logic              out_ready
);

  pa_state_t          state, state_next;
  logic               s1_valid, s1_last;
  logic [PROD_W-1:0]  s1_prod;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic [ACC_W:0]     acc_sum;
  logic               accept, take, handoff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A pending last beat blocks intake so a group never overlaps its result.
  assign in_ready = rst_n && !clear && (state != DONE) && !(s1_valid && s1_last);
  assign accept   = in_valid && in_ready;
  assign take     = s1_valid && (state != DONE);
  assign handoff  = (state == DONE) && out_ready;
  assign acc_sum  = {1'b0, acc} + {{(ACC_W - PROD_W + 1){1'b0}}, s1_prod};

  // S1: input register
  pa_in_reg #(.DATA_W(PROD_W)) u_in_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .flush     (clear),
    .data      (prod_in),
    .last      (in_last),
    .reg_valid (s1_valid),
    .reg_data  (s1_prod),
    .reg_last  (s1_last)
  );

  // S2: FSM and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACC: if (s1_valid) state_next = s1_last ? DONE : ACC;
      DONE:      if (out_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear || handoff) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (take) begin
      acc <= acc_sum[ACC_W-1:0];
      cnt <= sat_inc(cnt);
      ovf <= ovf | acc_sum[ACC_W];
    end
  end

  assign out_valid = (state == DONE);
  assign sum_out   = acc;
  assign cnt_out   = cnt;
  assign ovf_out   = ovf;

endmodule
